// File: rtl/operand_arbiter2.sv
// Two-requester arbiter for the shared 16-bit operand mux, with a registered output slot and bounded bursts.
// Optional feature: define ARB_RR_EN for a round-robin tie-break (default build uses fixed priority, A wins).
module operand_arbiter2 #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_src,
  input  logic             o_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sel_last_r;
`ifdef ARB_RR_EN
  logic             last_src_r;
`endif

  logic             space_s;
  logic             grant_vld_s;
  logic             grant_s;
  logic             accept_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             burst_end_s;

  // Grant selection: owner keeps the grant, IDLE arbitrates, no request keeps the last select.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = sel_last_r;
    case (state_r)
      IDLE: begin
        if (a_valid && b_valid) begin
          grant_vld_s = 1'b1;
`ifdef ARB_RR_EN
          grant_s     = ~last_src_r;
`else
          grant_s     = 1'b0;
`endif
        end else if (a_valid) begin
          grant_vld_s = 1'b1;
          grant_s     = 1'b0;
        end else if (b_valid) begin
          grant_vld_s = 1'b1;
          grant_s     = 1'b1;
        end else begin
          grant_vld_s = 1'b0;
          grant_s     = sel_last_r;
        end
      end
      OWN_A: begin
        grant_vld_s = 1'b1;
        grant_s     = 1'b0;
      end
      OWN_B: begin
        grant_vld_s = 1'b1;
        grant_s     = 1'b1;
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_s     = sel_last_r;
      end
    endcase
  end

  assign space_s     = !o_valid || o_ready;
  assign accept_s    = space_s && grant_vld_s && (grant_s ? b_valid : a_valid);
  assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign burst_end_s = (cnt_inc_s == CNT_W'(MAX_BURST));

  // Readies are forced low while reset is being applied so no beat is offered into a discarded slot.
  assign a_ready = rst_n && space_s && grant_vld_s && !grant_s;
  assign b_ready = rst_n && space_s && grant_vld_s &&  grant_s;
  assign sel     = grant_s;

  // Ownership FSM, burst counter and output slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      sel_last_r <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= {WIDTH{1'b0}};
      o_src      <= 1'b0;
`ifdef ARB_RR_EN
      last_src_r <= 1'b1;
`endif
    end else begin
      sel_last_r <= grant_s;

      if (accept_s) begin
        o_valid <= 1'b1;
        o_data  <= grant_s ? b_data : a_data;
        o_src   <= grant_s;
`ifdef ARB_RR_EN
        last_src_r <= grant_s;
`endif
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (MAX_BURST == 1) begin
              state_r <= IDLE;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              state_r <= grant_s ? OWN_B : OWN_A;
              cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        OWN_A, OWN_B: begin
          // Without slot space the owner simply waits; an absent owner valid releases the grant.
          if (space_s) begin
            if (accept_s && !burst_end_s) begin
              cnt_r <= cnt_inc_s;
            end else begin
              state_r <= IDLE;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
